roi_readout_decoder: RTL and testbench
======================================

# roi_readout_decoder

Receive side of the ROI trigger path. Accepts a 2-bit ROI index with a valid/ready handshake and decodes it to a one-hot region mask. It snapshots the four 8-bit region energies and streams a readout frame over a valid/ready/last byte interface with backpressure. The frame holds a header, then the selected region's energy with its two ring neighbours. Sits between the ROI max encoder and the readout/DAQ serializer.

## Interface
- TAG, 4'hA, 4-bit frame tag placed in header bits [7:4]
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- E0, E1, E2, E3  input  8 each  region energies, unsigned, sampled on ROI accept
- roi_valid  input  1  ROI index offered
- roi  input  2  ROI index (0..3)
- roi_ready  output  1  block can accept an ROI
- roi_onehot  output  4  decoded region mask, bit n = region n
- out_data  output  8  frame byte
- out_valid  output  1  out_data valid
- out_last  output  1  final byte of frame
- out_ready  input  1  downstream accepts byte
- busy  output  1  frame in progress

## Operation
- States: IDLE, HDR, LEFT, CENTER, RIGHT, plus SUM when ROI_SUM_EN is defined.
- IDLE: roi_ready=1, out_valid=0, roi_onehot=0, busy=0.
- Accept when roi_valid && roi_ready at a rising edge:
  - Register roi as r.
  - Snapshot E0..E3 into internal registers S0..S3.
  - roi_onehot <= 1<<r.
  - Go to HDR.
- HDR: out_data = {TAG, 2'b00, r}.
- LEFT: out_data = S[(r-1) mod 4].
- CENTER: out_data = S[r].
- RIGHT: out_data = S[(r+1) mod 4].
- Index arithmetic is 2-bit wrap-around. For r=0, LEFT=S3; for r=3, RIGHT=S0.
- Each state advances only on out_valid && out_ready. The final state returns to IDLE on acceptance.
- roi_ready=0 in every non-IDLE state. ROIs offered during a frame are not accepted, and no queueing occurs.
- busy=1 in every non-IDLE state.
- Energy inputs changing after accept do not affect the frame in flight.

## Timing
- Reset values: roi_ready=1, roi_onehot=4'b0000, out_data=8'h00, out_valid=0, out_last=0, busy=0, state=IDLE. Reset clears all of these asynchronously.
- Reset mid-frame aborts the frame immediately. No out_last is produced, and the next frame starts from HDR.
- Latency: header byte is presented (out_valid=1) the cycle after the accept edge.
- With out_ready held high, one byte per cycle. The frame lasts 4 cycles, or 5 with ROI_SUM_EN.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable. out_valid never drops without acceptance.
- out_last=1 only on the final byte of the frame.
- roi_onehot is valid from the cycle after accept until the cycle after the final byte is accepted; it is 0 otherwise.
- After the final accept the block spends at least one cycle in IDLE, with roi_ready=1, before it can accept the next ROI. The minimum frame-to-frame spacing is therefore frame length + 1 cycles.
- All outputs are registered; there is no combinational path from out_ready or roi_valid to any output.

## Configuration
- ROI_SUM_EN defined:
  - Adds a SUM byte after RIGHT: S[(r-1) mod 4] + S[r] + S[(r+1) mod 4], computed in 10 bits and saturated to 8'hFF if above 255.
  - out_last moves to SUM.
  - Frame length is 5 bytes.
- ROI_SUM_EN undefined:
  - The SUM state and adder are absent.
  - RIGHT carries out_last.
  - Frame length is 4 bytes.

## Test plan
- Reset then idle: rst_n low, then high with roi_valid=0 → roi_ready=1, out_valid=0, roi_onehot=0, busy=0.
- Basic frame: E0..E3=10,20,30,40, roi=2, out_ready=1 → onehot 4'b0100, bytes A2,14,1E,28. With ROI_SUM_EN, a fifth byte 5A. out_last on the final byte only.
- Wrap-around: roi=0 gives A0,28,0A,14. roi=3 gives A3,1E,28,0A.
- Backpressure and snapshot: hold out_ready=0 for 3 cycles on the CENTER byte and change E inputs meanwhile → out_data stable, out_valid held, and the frame carries the snapshot values.
- ROI offered mid-frame plus saturation: roi_valid asserted mid-frame → roi_ready=0, ignored; the next ROI is accepted one IDLE cycle after the final byte. With ROI_SUM_EN and E=200,200,200,0, roi=1 → SUM byte FF.
- Reset mid-frame: rst_n low during the LEFT byte → all outputs return to reset values asynchronously. After release, a new ROI produces a full frame starting with the header.

Source files
------------

// File: rtl/roi_readout_decoder_if.sv
// rtl/roi_readout_decoder_if.sv - ROI request handshake plus readout byte stream.
interface roi_readout_decoder_if;
  logic       roi_valid;
  logic [1:0] roi;
  logic       roi_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (
    output roi_valid,
    output roi,
    input  roi_ready,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

  modport slave (
    input  roi_valid,
    input  roi,
    output roi_ready,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );
endinterface

// File: rtl/roi_readout_decoder.sv
// rtl/roi_readout_decoder.sv - ROI index decode and header/left/center/right readout frame.
// Optional SUM byte (saturated neighbour sum) when ROI_SUM_EN is defined.
module roi_readout_decoder #(
  parameter logic [3:0] TAG = 4'hA
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  E0,
  input  logic [7:0]                  E1,
  input  logic [7:0]                  E2,
  input  logic [7:0]                  E3,
  roi_readout_decoder_if.slave        io,
  output logic [3:0]                  roi_onehot,
  output logic                        busy
);

`ifdef ROI_SUM_EN
  typedef enum logic [2:0] {IDLE, HDR, LEFT, CENTER, RIGHT, SUM} state_e;
  localparam state_e LAST_ST = SUM;
`else
  typedef enum logic [2:0] {IDLE, HDR, LEFT, CENTER, RIGHT} state_e;
  localparam state_e LAST_ST = RIGHT;
`endif

  state_e          state_q, state_d;
  logic [1:0]      r_q, r_d;
  logic [3:0][7:0] s_q, s_d;

  logic            roi_ready_q, roi_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [7:0]      out_data_q, out_data_d;
  logic [3:0]      onehot_q, onehot_d;
  logic            busy_q, busy_d;

  logic            accept;
  logic            advance;
  logic [1:0]      left_idx;
  logic [1:0]      right_idx;

  assign accept  = io.roi_valid && roi_ready_q;
  assign advance = out_valid_q && io.out_ready;

  // Neighbour indices wrap on the 4-region ring through 2-bit arithmetic.
  assign left_idx  = r_d - 2'd1;
  assign right_idx = r_d + 2'd1;

`ifdef ROI_SUM_EN
  logic [9:0] sum_full;
  logic [7:0] sum_sat;
  assign sum_full = {2'b00, s_d[left_idx]} + {2'b00, s_d[r_d]} + {2'b00, s_d[right_idx]};
  assign sum_sat  = (sum_full > 10'd255) ? 8'hFF : sum_full[7:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= 2'd0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HDR;
          r_d     = io.roi;
          s_d     = {E3, E2, E1, E0};
        end
      end
      HDR:    if (advance) state_d = LEFT;
      LEFT:   if (advance) state_d = CENTER;
      CENTER: if (advance) state_d = RIGHT;
`ifdef ROI_SUM_EN
      RIGHT:  if (advance) state_d = SUM;
      SUM:    if (advance) state_d = IDLE;
`else
      RIGHT:  if (advance) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so every port comes straight from a flop.
  always_comb begin
    out_data_d  = 8'h00;
    out_valid_d = 1'b1;
    out_last_d  = (state_d == LAST_ST);
    roi_ready_d = 1'b0;
    busy_d      = 1'b1;
    onehot_d    = 4'b0001 << r_d;
    case (state_d)
      HDR:    out_data_d = {TAG, 2'b00, r_d};
      LEFT:   out_data_d = s_d[left_idx];
      CENTER: out_data_d = s_d[r_d];
      RIGHT:  out_data_d = s_d[right_idx];
`ifdef ROI_SUM_EN
      SUM:    out_data_d = sum_sat;
`endif
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        roi_ready_d = 1'b1;
        busy_d      = 1'b0;
        onehot_d    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roi_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
      onehot_q    <= 4'b0000;
      busy_q      <= 1'b0;
    end else begin
      roi_ready_q <= roi_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      onehot_q    <= onehot_d;
      busy_q      <= busy_d;
    end
  end

  assign io.roi_ready = roi_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
  assign io.out_data  = out_data_q;
  assign roi_onehot   = onehot_q;
  assign busy         = busy_q;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !io.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_last_q)));

  a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(roi_ready_q && out_valid_q));

endmodule

// File: tb/tb_roi_readout_decoder.sv
// tb/tb_roi_readout_decoder.sv - table vectors, corner sequences and randomized frames vs a ring model.
module tb_roi_readout_decoder;

`ifdef ROI_SUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif
  localparam logic [3:0] TAG_EXP = 4'hA;
  localparam int BUDGET = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] e0 = 8'h00, e1 = 8'h00, e2 = 8'h00, e3 = 8'h00;
  logic [3:0] roi_onehot;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  roi_readout_decoder_if bus ();

  roi_readout_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .E0         (e0),
    .E1         (e1),
    .E2         (e2),
    .E3         (e3),
    .io         (bus),
    .roi_onehot (roi_onehot),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ev;
    logic [1:0]  r;
    logic [39:0] bytes;
    int          mode;
  } vec_t;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [39:0] model(input logic [31:0] ev, input logic [1:0] r);
    int s[4];
    int c, l, rr, sum;
    logic [39:0] res;
    for (int i = 0; i < 4; i++) s[i] = int'(ev[8*i +: 8]);
    c  = int'(r);
    l  = (c + 3) % 4;
    rr = (c + 1) % 4;
    sum = s[l] + s[c] + s[rr];
    if (sum > 255) sum = 255;
    res[7:0]   = {TAG_EXP, 2'b00, r};
    res[15:8]  = 8'(s[l]);
    res[23:16] = 8'(s[c]);
    res[31:24] = 8'(s[rr]);
    res[39:32] = 8'(sum);
    return res;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 40'(bus.roi_ready), 40'd1);
    chk({tag, "_valid"}, 40'(bus.out_valid), 40'd0);
    chk({tag, "_last"}, 40'(bus.out_last), 40'd0);
    chk({tag, "_onehot"}, 40'(roi_onehot), 40'd0);
    chk({tag, "_busy"}, 40'(busy), 40'd0);
  endtask

  // mode 0: out_ready high; 1: random ready, E churn and mid-frame ROI offers;
  // 2: stall CENTER three cycles while E changes.
  task automatic run_frame(input logic [31:0] ev, input logic [1:0] r,
                           input logic [39:0] bytes, input int mode);
    int idx;
    int cyc;
    int stall;
    logic rdy;
    chk("accept_ready", 40'(bus.roi_ready), 40'd1);
    {e3, e2, e1, e0} = ev;
    bus.roi       = r;
    bus.roi_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.roi_valid = 1'b0;
    idx = 0;
    cyc = 0;
    stall = 0;
    while (idx < FRAME_LEN && cyc < BUDGET) begin
      chk("valid", 40'(bus.out_valid), 40'd1);
      chk("data", 40'(bus.out_data), 40'(bytes[8*idx +: 8]));
      chk("last", 40'(bus.out_last), 40'(idx == FRAME_LEN - 1));
      chk("onehot", 40'(roi_onehot), 40'(4'b0001 << r));
      chk("busy", 40'(busy), 40'd1);
      chk("ready_busy", 40'(bus.roi_ready), 40'd0);
      rdy = 1'b1;
      if (mode == 1) begin
        rdy = 1'($urandom_range(0, 1));
        {e3, e2, e1, e0} = $urandom;
        bus.roi_valid = 1'($urandom_range(0, 1));
        bus.roi = 2'($urandom_range(0, 3));
      end else if (mode == 2 && idx == 2 && stall < 3) begin
        rdy = 1'b0;
        stall++;
        {e3, e2, e1, e0} = $urandom;
      end
      bus.out_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    if (cyc >= BUDGET) chk("frame_budget", 40'(cyc), 40'(BUDGET - 1));
    bus.roi_valid = 1'b0;
    bus.out_ready = 1'b0;
    check_idle("post");
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h281E140A, 2'd2, 40'h5A281E14A2, 0};
    vecs[1] = '{32'h281E140A, 2'd0, 40'h46140A28A0, 0};
    vecs[2] = '{32'h281E140A, 2'd3, 40'h500A281EA3, 0};
    vecs[3] = '{32'h00C8C8C8, 2'd1, 40'hFFC8C8C8A1, 1};
    vecs[4] = '{32'h00C8C8C8, 2'd0, 40'hFFC8C800A0, 0};
    vecs[5] = '{32'h281E140A, 2'd1, 40'h3C1E140AA1, 2};

    bus.roi_valid = 1'b0;
    bus.roi       = 2'd0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    chk("reset_data", 40'(bus.out_data), 40'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle");

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].ev, vecs[i].r, vecs[i].bytes, vecs[i].mode);

    // Reset during the LEFT byte: outputs clear before any clock edge.
    {e3, e2, e1, e0} = 32'h281E140A;
    bus.roi = 2'd1;
    bus.roi_valid = 1'b1;
    @(negedge clk);
    bus.roi_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("rst_left_data", 40'(bus.out_data), 40'h0A);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_data", 40'(bus.out_data), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(32'h281E140A, 2'd1, 40'h3C1E140AA1, 0);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] ev;
      logic [1:0]  r;
      ev = $urandom;
      r  = 2'($urandom_range(0, 3));
      run_frame(ev, r, model(ev, r), (k % 3 == 2) ? 0 : 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
